// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FWFT result queue behind the ALU with flag register and sticky overflow.
// Optional macro ALU_RESULT_PARITY_EN adds a stored even-parity bit per entry and the out_parity port.
module alu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_y,
  input  logic [3:0]               in_op,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_y,
  output logic [3:0]               out_op,
  output logic [3:0]               out_flags,
`ifdef ALU_RESULT_PARITY_EN
  output logic                     out_parity,
`endif
  output logic [3:0]               flags_q,
  output logic                     sticky_o,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] y_mem   [DEPTH];
  logic [3:0]        op_mem  [DEPTH];
  logic [3:0]        flg_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    flags_d;
  logic          sticky_q, sticky_d;
  logic          push, pop;

  // Last popped entry, presented on out_* while the queue is empty.
  logic [DATA_W-1:0] last_y_q;
  logic [3:0]        last_op_q, last_flg_q;

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign sticky_o  = sticky_q;

  assign out_y     = out_valid ? y_mem[rd_ptr_q]   : last_y_q;
  assign out_op    = out_valid ? op_mem[rd_ptr_q]  : last_op_q;
  assign out_flags = out_valid ? flg_mem[rd_ptr_q] : last_flg_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Arithmetic ops own carry/overflow; logic ops only refresh Z and N.
    if (push) begin
      if (in_op < 4'd3) flags_d = in_flags;
      else              flags_d = {flags_q[3:2], in_flags[1:0]};
    end
    if (push && in_flags[3]) sticky_d = 1'b1;
    else if (clr_sticky)     sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      y_mem[wr_ptr_q]   <= in_y;
      op_mem[wr_ptr_q]  <= in_op;
      flg_mem[wr_ptr_q] <= in_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flags_q    <= 4'b0000;
      sticky_q   <= 1'b0;
      last_y_q   <= '0;
      last_op_q  <= '0;
      last_flg_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      if (pop) begin
        last_y_q   <= y_mem[rd_ptr_q];
        last_op_q  <= op_mem[rd_ptr_q];
        last_flg_q <= flg_mem[rd_ptr_q];
      end
    end
  end

`ifdef ALU_RESULT_PARITY_EN
  logic par_mem [DEPTH];
  logic last_par_q;

  assign out_parity = out_valid ? par_mem[rd_ptr_q] : last_par_q;

  always_ff @(posedge clk) begin
    if (push) par_mem[wr_ptr_q] <= ^in_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last_par_q <= 1'b0;
    else if (pop) last_par_q <= par_mem[rd_ptr_q];
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard bench for alu_result_buffer with randomized traffic.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, clr_sticky, sticky_o;
  logic [31:0] in_y, out_y;
  logic [3:0]  in_op, in_flags, out_op, out_flags, flags_q;
  logic [2:0]  count;
`ifdef ALU_RESULT_PARITY_EN
  logic        out_parity;
`endif

  alu_result_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .out_flags(out_flags),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity(out_parity),
`endif
    .flags_q(flags_q), .sticky_o(sticky_o), .clr_sticky(clr_sticky), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  op;
    logic [3:0]  fl;
  } ent_t;

  ent_t sb[$];
  ent_t m_last;
  logic [3:0] m_flags;
  logic m_sticky;
  logic hold_q;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compares DUT state against the model, then folds in this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_flags = 4'b0;
      m_sticky = 1'b0;
      m_last = '{y: 32'h0, op: 4'h0, fl: 4'h0};
      hold_q = 1'b0;
    end else begin
      bit do_push, do_pop;
      check("count", 64'(count), 64'(sb.size()));
      check("in_ready", 64'(in_ready), 64'(sb.size() < 4));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("flags_q", 64'(flags_q), 64'(m_flags));
      check("sticky_o", 64'(sticky_o), 64'(m_sticky));
      if (sb.size() != 0) begin
        check("out_y", 64'(out_y), 64'(sb[0].y));
        check("out_op", 64'(out_op), 64'(sb[0].op));
        check("out_flags", 64'(out_flags), 64'(sb[0].fl));
`ifdef ALU_RESULT_PARITY_EN
        check("out_parity", 64'(out_parity), 64'(^sb[0].y));
`endif
      end else begin
        check("out_y_hold", 64'(out_y), 64'(m_last.y));
        check("out_op_hold", 64'(out_op), 64'(m_last.op));
        check("out_flags_hold", 64'(out_flags), 64'(m_last.fl));
`ifdef ALU_RESULT_PARITY_EN
        check("out_parity_hold", 64'(out_parity), 64'(^m_last.y));
`endif
      end
      if (hold_q) check("in_valid_held", 64'(in_valid), 64'(1));
      do_push = in_valid && (sb.size() < 4);
      do_pop  = out_ready && (sb.size() != 0);
      if (do_pop) m_last = sb.pop_front();
      if (do_push) begin
        sb.push_back('{y: in_y, op: in_op, fl: in_flags});
        if (in_op <= 4'd2) m_flags = in_flags;
        else               m_flags = {m_flags[3:2], in_flags[1:0]};
      end
      if (do_push && in_flags[3]) m_sticky = 1'b1;
      else if (clr_sticky)        m_sticky = 1'b0;
      hold_q = in_valid && !do_push;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] y, input logic [3:0] op, input logic [3:0] fl, input logic clr);
    bit acc, done;
    in_valid = 1'b1; in_y = y; in_op = op; in_flags = fl; clr_sticky = clr;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = in_ready;
      tick();
      clr_sticky = 1'b0;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_y = 0; in_op = 0; in_flags = 0; out_ready = 0; clr_sticky = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_flags", 64'(flags_q), 64'(0));
    check("rst_sticky", 64'(sticky_o), 64'(0));

    for (int i = 1; i <= 4; i++) send(32'(i), 4'd0, 4'd0, 1'b0);
    check("full_count", 64'(count), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    repeat (4) tick();
    check("drained_count", 64'(count), 64'(0));
    out_ready = 1'b0;

    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 4'd1, 4'd0, 1'b0);
    in_valid = 1'b1; in_y = 32'h99; in_op = 4'd2; in_flags = 4'd0; out_ready = 1'b1;
    tick();
    check("full_pop_count", 64'(count), 64'(3));
    check("full_pop_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    out_ready = 1'b0;

    send(32'hA, 4'd0, 4'b1010, 1'b0);
    check("flags_arith", 64'(flags_q), 64'(4'b1010));
    send(32'hB, 4'd3, 4'b0001, 1'b0);
    check("flags_logic", 64'(flags_q), 64'(4'b1001));
    check("sticky_set", 64'(sticky_o), 64'(1));
    send(32'hC, 4'd5, 4'b1000, 1'b1);
    check("sticky_set_wins", 64'(sticky_o), 64'(1));
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_cleared", 64'(sticky_o), 64'(0));
    out_ready = 1'b1;
    repeat (4) tick();

    for (int c = 0; c < 400; c++) begin
      bit pend;
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      pend = in_valid && in_ready;
      if (!in_valid && ($urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1; in_y = $urandom(); in_op = 4'($urandom_range(0, 15));
        in_flags = 4'($urandom_range(0, 15));
      end
      tick();
      if (pend) in_valid = 1'b0;
    end
    in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    out_ready = 1'b0;
    send(32'h55, 4'd0, 4'd0, 1'b0);
    send(32'h66, 4'd0, 4'd0, 1'b0);
    check("pre_rst_count", 64'(count), 64'(2));
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_count", 64'(count), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    send(32'h0000_0007, 4'd4, 4'd0, 1'b0);
`ifdef ALU_RESULT_PARITY_EN
    check("parity_7", 64'(out_parity), 64'(1));
`endif
    check("post_rst_y", 64'(out_y), 64'(32'h7));
    out_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
